// File: rtl/smvm_stream_packer_if.sv
// Host and SMVM-side signal bundle for smvm_stream_packer.
//
// Host channels (valid/ready):
//   cfg : cfg_valid/cfg_ready, cfg_rows[8:0], cfg_cols[8:0]
//   vec : vec_valid/vec_ready, vec_data[7:0]
//   nz  : nz_valid/nz_ready, nz_val[7:0], nz_col[8:0], nz_row_last, nz_last
// SMVM side: val_in[7:0], ipv_in, in_valid
// Status   : busy, err_cfg (pulse), err_overflow (sticky)
//
// The slave modport is the packer's view; master is the host/bench view.
interface smvm_stream_packer_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [8:0] cfg_rows;
  logic [8:0] cfg_cols;
  logic       vec_valid;
  logic       vec_ready;
  logic [7:0] vec_data;
  logic       nz_valid;
  logic       nz_ready;
  logic [7:0] nz_val;
  logic [8:0] nz_col;
  logic       nz_row_last;
  logic       nz_last;
  logic [7:0] val_in;
  logic       ipv_in;
  logic       in_valid;
  logic       busy;
  logic       err_cfg;
  logic       err_overflow;

  modport slave (
    input  cfg_valid, cfg_rows, cfg_cols,
    input  vec_valid, vec_data,
    input  nz_valid, nz_val, nz_col, nz_row_last, nz_last,
    output cfg_ready, vec_ready, nz_ready,
    output val_in, ipv_in, in_valid,
    output busy, err_cfg, err_overflow
  );

  modport master (
    output cfg_valid, cfg_rows, cfg_cols,
    output vec_valid, vec_data,
    output nz_valid, nz_val, nz_col, nz_row_last, nz_last,
    input  cfg_ready, vec_ready, nz_ready,
    input  val_in, ipv_in, in_valid,
    input  busy, err_cfg, err_overflow
  );
endinterface

// File: rtl/smvm_stream_packer.sv
// smvm_stream_packer: buffers one SMVM job (shape, dense vector, nonzero
// list) from the host, then replays it to SMVM as one gap-free serial stream:
// rows, cols, vector bytes, then (value, column) pairs padded to a multiple
// of K, followed by DRAIN idle cycles so SMVM can settle back to IDLE.
//
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - smvm_stream_packer_if.slave (host channels, SMVM stream, status)
module smvm_stream_packer #(
  parameter int K        = 4,
  parameter int MAX_COLS = 256,
  parameter int MAX_NNZ  = 64,
  parameter int DRAIN    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  smvm_stream_packer_if.slave   bus
);

  localparam int VAW = $clog2(MAX_COLS);
  localparam int NAW = $clog2(MAX_NNZ);
  localparam int PW  = $clog2(MAX_NNZ + K + 1);
  localparam int GW  = $clog2(DRAIN + 1);
  localparam logic [8:0]    COLS_LIM = 9'(MAX_COLS);
  localparam logic [PW-1:0] NNZ_LAST = PW'(MAX_NNZ - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(DRAIN - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD_VEC, LOAD_NZ, ABORT,
    EMIT_ROWS, EMIT_COLS, EMIT_VEC, EMIT_VAL, EMIT_IDX, GAP
  } state_t;

  state_t state;

  logic [8:0]    rows_r, cols_r, vcnt;
  logic [PW-1:0] ncnt, nnz_r, pairs_r, pidx;
  logic [GW-1:0] gcnt;
  logic [7:0]    val_q;
  logic          ipv_q, in_valid_q, busy_q, err_cfg_q, err_ovf_q;

  // Value/row_last and column are kept in separate arrays so each read
  // uses its whole word.
  logic [7:0] vec_mem    [MAX_COLS];
  logic [8:0] nz_vr_mem  [MAX_NNZ];
  logic [8:0] nz_col_mem [MAX_NNZ];

  logic          vec_we, nz_we;
  logic [PW-1:0] nnz_next, pairs_next, val_sel;
  logic [8:0]    val_word, col_word;
  logic [VAW-1:0] vec_next;

  assign bus.cfg_ready    = (state == IDLE);
  assign bus.vec_ready    = (state == LOAD_VEC);
  assign bus.nz_ready     = (state == LOAD_NZ) || (state == ABORT);
  assign bus.val_in       = val_q;
  assign bus.ipv_in       = ipv_q;
  assign bus.in_valid     = in_valid_q;
  assign bus.busy         = busy_q;
  assign bus.err_cfg      = err_cfg_q;
  assign bus.err_overflow = err_ovf_q;

  // Outputs are registered one state ahead, so the word for the next cycle
  // is looked up here. val_sel is the pair whose value goes out next: pair 0
  // when leaving the vector, otherwise the one after the current pair.
  // Pairs at or beyond nnz are padding and read as zero.
  always_comb begin
    vec_we     = (state == LOAD_VEC) && bus.vec_valid;
    nz_we      = (state == LOAD_NZ) && bus.nz_valid;
    nnz_next   = ncnt + 1'b1;
    pairs_next = PW'((32'(nnz_next) + K - 1) / K * K);
    val_sel    = (state == EMIT_IDX) ? pidx + 1'b1 : '0;
    val_word   = (val_sel < nnz_r) ? nz_vr_mem[val_sel[NAW-1:0]] : '0;
    col_word   = (pidx < nnz_r) ? nz_col_mem[pidx[NAW-1:0]] : '0;
    vec_next   = vcnt[VAW-1:0] + 1'b1;
  end

  // Job buffers; contents are always written before being read, so they
  // carry no reset.
  always_ff @(posedge clk) begin
    if (vec_we)
      vec_mem[vcnt[VAW-1:0]] <= bus.vec_data;
    if (nz_we) begin
      nz_vr_mem[ncnt[NAW-1:0]]  <= {bus.nz_val, bus.nz_row_last};
      nz_col_mem[ncnt[NAW-1:0]] <= bus.nz_col;
    end
  end

  // Main FSM. Every transition also loads the output registers with what the
  // new state must present, which keeps in_valid continuous across states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rows_r     <= '0;
      cols_r     <= '0;
      vcnt       <= '0;
      ncnt       <= '0;
      nnz_r      <= '0;
      pairs_r    <= '0;
      pidx       <= '0;
      gcnt       <= '0;
      val_q      <= '0;
      ipv_q      <= 1'b0;
      in_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_cfg_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      err_cfg_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            if (bus.cfg_cols == '0 || bus.cfg_cols > COLS_LIM) begin
              err_cfg_q <= 1'b1;
            end else begin
              rows_r    <= bus.cfg_rows;
              cols_r    <= bus.cfg_cols;
              err_ovf_q <= 1'b0;
              vcnt      <= '0;
              busy_q    <= 1'b1;
              state     <= LOAD_VEC;
            end
          end
        end
        LOAD_VEC: begin
          if (bus.vec_valid) begin
            if (vcnt == cols_r - 9'd1) begin
              ncnt  <= '0;
              state <= LOAD_NZ;
            end else begin
              vcnt <= vcnt + 9'd1;
            end
          end
        end
        LOAD_NZ: begin
          if (bus.nz_valid) begin
            if (bus.nz_last) begin
              nnz_r           <= nnz_next;
              pairs_r         <= pairs_next;
              in_valid_q      <= 1'b1;
              {val_q, ipv_q}  <= rows_r;
              state           <= EMIT_ROWS;
            end else if (ncnt == NNZ_LAST) begin
              err_ovf_q <= 1'b1;
              state     <= ABORT;
            end else begin
              ncnt <= nnz_next;
            end
          end
        end
        ABORT: begin
          if (bus.nz_valid && bus.nz_last) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        EMIT_ROWS: begin
          {val_q, ipv_q} <= cols_r;
          state          <= EMIT_COLS;
        end
        EMIT_COLS: begin
          val_q <= vec_mem['0];
          ipv_q <= 1'b0;
          vcnt  <= '0;
          state <= EMIT_VEC;
        end
        EMIT_VEC: begin
          if (vcnt == cols_r - 9'd1) begin
            {val_q, ipv_q} <= val_word;
            pidx           <= '0;
            state          <= EMIT_VAL;
          end else begin
            val_q <= vec_mem[vec_next];
            vcnt  <= vcnt + 9'd1;
          end
        end
        EMIT_VAL: begin
          {val_q, ipv_q} <= col_word;
          state          <= EMIT_IDX;
        end
        EMIT_IDX: begin
          if (pidx == pairs_r - 1'b1) begin
            in_valid_q <= 1'b0;
            val_q      <= '0;
            ipv_q      <= 1'b0;
            gcnt       <= '0;
            state      <= GAP;
          end else begin
            {val_q, ipv_q} <= val_word;
            pidx           <= pidx + 1'b1;
            state          <= EMIT_VAL;
          end
        end
        GAP: begin
          if (gcnt == GAP_LAST) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smvm_stream_packer.sv
// Self-checking bench for smvm_stream_packer. Jobs are built as plain
// queues; the expected SMVM stream is derived from them and compared cycle
// by cycle, including the drain gap and the return to IDLE.
module tb_smvm_stream_packer;
  localparam int K        = 4;
  localparam int MAX_COLS = 256;
  localparam int MAX_NNZ  = 64;
  localparam int DRAIN    = 8;
  localparam int BOUND    = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  smvm_stream_packer_if bus();

  smvm_stream_packer #(
    .K(K), .MAX_COLS(MAX_COLS), .MAX_NNZ(MAX_NNZ), .DRAIN(DRAIN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int valid_seen = 0;
  int stall_pct = 0;

  int unsigned j_rows, j_cols;
  logic [7:0]  j_vec[$];
  logic [7:0]  j_val[$];
  logic [8:0]  j_col[$];
  logic        j_rl[$];
  logic [8:0]  exp_q[$];

  // Counts SMVM-side valid cycles so aborted jobs can be shown to emit nothing.
  always @(negedge clk) if (bus.in_valid) valid_seen++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference stream: header, vector, then P = ceil(nnz/K)*K pairs with zero padding.
  function automatic void buildExpected();
    int nnz = j_val.size();
    int p_total = ((nnz + K - 1) / K) * K;
    exp_q.delete();
    exp_q.push_back(j_rows[8:0]);
    exp_q.push_back(j_cols[8:0]);
    foreach (j_vec[i]) exp_q.push_back({j_vec[i], 1'b0});
    for (int p = 0; p < p_total; p++) begin
      if (p < nnz) begin
        exp_q.push_back({j_val[p], j_rl[p]});
        exp_q.push_back(j_col[p]);
      end else begin
        exp_q.push_back(9'd0);
        exp_q.push_back(9'd0);
      end
    end
  endfunction

  function automatic void makeJob(input int unsigned rows, input int unsigned cols, input int nnz);
    j_rows = rows;
    j_cols = cols;
    j_vec.delete(); j_val.delete(); j_col.delete(); j_rl.delete();
    for (int i = 0; i < int'(cols); i++) j_vec.push_back(8'($urandom));
    for (int i = 0; i < nnz; i++) begin
      j_val.push_back(8'($urandom));
      j_col.push_back(9'($urandom));
      j_rl.push_back(1'($urandom));
    end
  endfunction

  function automatic void setBasicJob();
    j_rows = 3;
    j_cols = 4;
    j_vec = '{8'd10, 8'd20, 8'd30, 8'd40};
    j_val = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    j_col = '{9'd0, 9'd3, 9'd1, 9'd2, 9'd3};
    j_rl  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  endfunction

  task automatic maybeStall();
    if (int'($urandom_range(0, 99)) < stall_pct)
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
  endtask

  function automatic logic readyOf(input int ch);
    case (ch)
      0:       return bus.cfg_ready;
      1:       return bus.vec_ready;
      default: return bus.nz_ready;
    endcase
  endfunction

  // Valid is already up; waits (bounded) for ready, then lets the edge transfer.
  task automatic handshake(input int ch, input string tag);
    int n = 0;
    while (!readyOf(ch) && n < BOUND) begin @(posedge clk); #1; n++; end
    if (n == BOUND) checkOutput({tag, "_ready_timeout"}, 32'(0), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus();
    maybeStall();
    bus.cfg_valid = 1'b1;
    bus.cfg_rows  = j_rows[8:0];
    bus.cfg_cols  = j_cols[8:0];
    handshake(0, "cfg");
    bus.cfg_valid = 1'b0;
    checkOutput("cfg_accept", 32'({bus.busy, bus.err_overflow}), 32'(2'b10));
    foreach (j_vec[i]) begin
      maybeStall();
      bus.vec_valid = 1'b1;
      bus.vec_data  = j_vec[i];
      handshake(1, "vec");
      bus.vec_valid = 1'b0;
    end
    foreach (j_val[i]) begin
      maybeStall();
      bus.nz_valid    = 1'b1;
      bus.nz_val      = j_val[i];
      bus.nz_col      = j_col[i];
      bus.nz_row_last = j_rl[i];
      bus.nz_last     = (i == j_val.size() - 1);
      handshake(2, "nz");
      bus.nz_valid = 1'b0;
      bus.nz_last  = 1'b0;
    end
  endtask

  // Starts in the cycle right after the nz_last handshake.
  task automatic checkStream(input string tag);
    foreach (exp_q[i]) begin
      @(negedge clk);
      checkOutput($sformatf("%s_word%0d", tag, i),
                  32'({bus.in_valid, bus.val_in, bus.ipv_in}), 32'({1'b1, exp_q[i]}));
    end
    for (int g = 0; g < DRAIN; g++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_gap%0d", tag, g),
                  32'({bus.in_valid, bus.val_in, bus.ipv_in, bus.busy}), 32'(11'h001));
    end
    @(negedge clk);
    checkOutput({tag, "_idle"}, 32'({bus.busy, bus.cfg_ready}), 32'(2'b01));
    @(posedge clk); #1;
  endtask

  task automatic runJob(input string tag);
    buildExpected();
    applyStimulus();
    checkStream(tag);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int vs;
    bus.cfg_valid = 1'b0; bus.cfg_rows = '0; bus.cfg_cols = '0;
    bus.vec_valid = 1'b0; bus.vec_data = '0;
    bus.nz_valid = 1'b0; bus.nz_val = '0; bus.nz_col = '0;
    bus.nz_row_last = 1'b0; bus.nz_last = 1'b0;

    #12;
    checkOutput("reset_outputs", 32'({bus.in_valid, bus.val_in, bus.ipv_in, bus.busy,
                bus.err_cfg, bus.err_overflow}), 32'(0));
    checkOutput("reset_ready", 32'({bus.cfg_ready, bus.vec_ready, bus.nz_ready}), 32'(3'b100));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    setBasicJob();
    runJob("basic");

    makeJob(7, 3, 4);
    runJob("exact_k");

    // Rejected shapes: one err_cfg pulse each, FSM stays idle.
    for (int b = 0; b < 2; b++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_rows  = 9'd5;
      bus.cfg_cols  = (b == 0) ? 9'd0 : 9'd257;
      handshake(0, "badcfg");
      bus.cfg_valid = 1'b0;
      checkOutput($sformatf("badcfg%0d_pulse", b),
                  32'({bus.err_cfg, bus.busy, bus.cfg_ready, bus.vec_ready}), 32'(4'b1010));
      @(posedge clk); #1;
      checkOutput($sformatf("badcfg%0d_clear", b), 32'({bus.err_cfg, bus.busy}), 32'(0));
    end

    // Overflow: MAX_NNZ+3 entries, last one flagged.
    makeJob(5, 2, MAX_NNZ + 3);
    vs = valid_seen;
    applyStimulus();
    checkOutput("ovf_state", 32'({bus.busy, bus.cfg_ready, bus.err_overflow}), 32'(3'b011));
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("ovf_sticky", 32'(bus.err_overflow), 32'(1));
    checkOutput("ovf_no_emit", 32'(valid_seen), 32'(vs));

    makeJob(2, 5, 6);
    runJob("after_ovf");

    stall_pct = 50;
    setBasicJob();
    runJob("stall_basic");

    stall_pct = 20;
    makeJob(11, MAX_COLS, 1);
    runJob("maxcols_nnz1");
    makeJob(300, 6, MAX_NNZ);
    runJob("max_nnz");

    stall_pct = 30;
    for (int r = 0; r < 5; r++) begin
      makeJob($urandom_range(0, 511), $urandom_range(1, 12), int'($urandom_range(1, MAX_NNZ)));
      runJob($sformatf("rand%0d", r));
    end

    // Reset while the vector is streaming.
    stall_pct = 0;
    makeJob(9, 16, 5);
    applyStimulus();
    repeat (4) @(posedge clk);
    #2;
    checkOutput("rst_pre_valid", 32'(bus.in_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 32'({bus.in_valid, bus.busy, bus.val_in, bus.ipv_in}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    makeJob(4, 7, 9);
    runJob("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/smvm_stream_packer.md
Name: smvm_stream_packer

Overview:
Upstream feeder for the SMVM core. It accepts one job from a host over three valid/ready channels: the shape, the dense vector, and the nonzero entries in row-major order. Because SMVM cannot apply backpressure, the packer buffers the whole job internally. It then replays the job as one contiguous serial stream on SMVM's val_in/ipv_in/in_valid interface, padding the nonzero list to a multiple of K entries, and holds a drain gap so SMVM can return to IDLE.

Parameters:
K, 4, SMVM group size; the pair count emitted is rounded up to a multiple of K.
MAX_COLS, 256, vector buffer depth in bytes.
MAX_NNZ, 64, nonzero buffer depth in entries.
DRAIN, 8, idle cycles after the last pair. Must be ≥ 7 (SMVM CAL + RST + IDLE return).

Ports:
clk  in  1  clock
rst_n  in  1  reset
cfg_valid  in  1  shape valid
cfg_ready  out  1  high only in IDLE
cfg_rows  in  9  row count
cfg_cols  in  9  column count, 1..MAX_COLS
vec_valid  in  1  vector byte valid
vec_ready  out  1  vector byte ready
vec_data  in  8  vector element
nz_valid  in  1  nonzero entry valid
nz_ready  out  1  nonzero entry ready
nz_val  in  8  matrix value
nz_col  in  9  column index
nz_row_last  in  1  entry is the last of its row; forwarded as ipv
nz_last  in  1  final entry of the job
val_in  out  8  to SMVM val_in
ipv_in  out  1  to SMVM ipv_in
in_valid  out  1  to SMVM in_valid
busy  out  1  high in any state other than IDLE
err_cfg  out  1  one-cycle pulse when a shape is rejected
err_overflow  out  1  sticky; cleared by the next accepted cfg

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low.
- Reset state: FSM=IDLE; all counters 0; outputs val_in=0, ipv_in=0, in_valid=0, busy=0, err_cfg=0, err_overflow=0. Buffer contents need no reset.
- All SMVM-side outputs are registered.
- 9-bit fields are sent as {val_in, ipv_in}: val_in=x[8:1], ipv_in=x[0].
- Handshakes: a transfer occurs when valid && ready are both high on a rising edge. Ready signals do not depend combinationally on valid.
- FSM states:
  - IDLE: cfg_ready=1. On a cfg handshake:
    - cols==0 or cols>MAX_COLS → pulse err_cfg, stay in IDLE.
    - otherwise → latch rows/cols, clear err_overflow, go to LOAD_VEC.
  - LOAD_VEC: vec_ready=1. Write byte to buffer[vcnt]. After cols bytes → LOAD_NZ.
  - LOAD_NZ: nz_ready=1. Store {val, col, row_last} at ncnt.
    - On handshake with nz_last=1 → EMIT_ROWS.
    - If ncnt reaches MAX_NNZ without nz_last → set err_overflow, go to ABORT.
  - ABORT: nz_ready=1. Discard entries until nz_last is accepted, then go to IDLE. No emission occurs.
  - EMIT_ROWS (1 cycle): in_valid=1, sends rows.
  - EMIT_COLS (1 cycle): in_valid=1, sends cols.
  - EMIT_VEC (cols cycles): in_valid=1, val_in=vec[i], ipv_in=0.
  - EMIT_VAL / EMIT_IDX alternate, P pairs total, P = ceil(nnz/K)*K:
    - EMIT_VAL: in_valid=1, val_in=val, ipv_in=row_last.
    - EMIT_IDX: in_valid=1, sends col.
    - Pad pairs (index ≥ nnz) carry val=0, ipv=0, col=0.
  - GAP (DRAIN cycles): in_valid=0, val_in=0, ipv_in=0. Then → IDLE.
- in_valid is high on every cycle from EMIT_ROWS through the last EMIT_IDX, with no bubbles. The stream is 2+cols+2P cycles long.
- First EMIT_ROWS output occurs on the cycle after the nz_last handshake.
- A job with nz_last on its first entry is legal: nnz=1, P=K.
- nnz==MAX_NNZ with nz_last on the final entry is legal; this is not an overflow.
- Inputs arriving outside the owning state are ignored, since the corresponding ready is low.
- Reset mid-operation: the stream aborts immediately (in_valid=0). Both blocks share rst_n, so SMVM also resets.

Test Plan:
- Basic job: rows=3, cols=4, vec=[10,20,30,40], nz=(5,c0,rl0),(6,c3,rl1),(7,c1,rl1),(8,c2,rl0),(9,c3,rl1,last) → stream is:
  - (1,1), (2,0), 10, 20, 30, 40
  - (5,0),(0,0); (6,1),(1,1); (7,1),(0,1); (8,0),(1,0); (9,1),(1,1)
  - three pad pairs (0,0),(0,0)
  - 22 consecutive in_valid cycles, then 8 low, then busy falls and cfg_ready rises.
- Exact multiple of K: nnz=4 → P=4, no pad pairs; stream length = 2+cols+8.
- Bad shape: cfg_cols=0, then cfg_cols=257 → each gives one err_cfg pulse; FSM stays IDLE; vec_ready=0.
- Overflow: MAX_NNZ+3 entries with nz_last on the last one → err_overflow=1, in_valid never rises, return to IDLE. A following valid cfg clears err_overflow.
- Host stalls: vec_valid/nz_valid toggled randomly → emitted stream is identical to the basic-job case and contiguous.
- Reset mid-stream: assert rst_n low during EMIT_VEC → in_valid=0 asynchronously; after release, a new job completes normally.
